prco_mem_wb: RTL and testbench
==============================

Name: prco_mem_wb

Overview:
- Memory-access / write-back stage directly downstream of the ALU.
- Consumes the ALU result, its RAM/register strobes and its branch flag. Performs LW/SW transactions on the data-RAM port, writes results into the register file, and issues PC redirects to fetch.
- Holds q_busy while a RAM transaction is outstanding so that decode/ALU stall.

Parameters:
- DATA_W, 16, datapath and RAM word width.
- REG_SEL_W, 3, register-file index width.
- TIMEOUT_CYCLES, 255, RAM wait limit in cycles; used only with the optional feature. Range 1..255, 8-bit counter.

Ports:
- i_clk  in  1  stage clock; all state updates on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_ce_ram  in  1  ALU result is a RAM address (LW/SW); one-cycle strobe.
- i_ce_reg  in  1  ALU result goes to the register file or PC; one-cycle strobe.
- i_op  in  5  opcode accompanying the strobe (`PRCO_OP_* encoding).
- i_result  in  DATA_W  ALU result: address, write-back value, or jump target.
- i_store_data  in  DATA_W  SW store value.
- i_dst_reg  in  REG_SEL_W  destination register index.
- i_should_branch  in  1  ALU branch-taken flag.
- i_ram_ack  in  1  RAM transaction complete.
- i_ram_rdata  in  DATA_W  RAM read data; valid only while i_ram_ack=1.
- q_ram_req  out  1  RAM request; held until ack.
- q_ram_we  out  1  RAM write enable; 1 for SW.
- q_ram_addr  out  DATA_W  RAM address.
- q_ram_wdata  out  DATA_W  RAM write data.
- q_reg_we  out  1  register-file write pulse.
- q_reg_sel  out  REG_SEL_W  register-file write index.
- q_reg_wdata  out  DATA_W  register-file write data.
- q_pc_load  out  1  PC redirect pulse.
- q_pc_value  out  DATA_W  redirect target.
- q_busy  out  1  stage occupied; upstream must hold.
- q_done  out  1  one-cycle pulse on instruction retirement.
- q_fault  out  1  sticky RAM-timeout flag; optional feature.

Behaviour:
- Reset:
  - All outputs 0; state IDLE.
  - A reset during RAM_WAIT drops q_ram_req at that edge.
  - Any in-flight write-back is discarded.
- States: IDLE, RAM_WAIT, WRITEBACK.
- IDLE, i_ce_ram=1:
  - Latch op, address (i_result), store data and dst.
  - At that edge: q_ram_req=1, q_ram_we=(i_op==`PRCO_OP_SW), q_busy=1, go to RAM_WAIT.
  - i_ce_ram takes priority if both strobes are high; i_ce_reg is then dropped.
- IDLE, i_ce_reg=1 (latency 1 cycle, registered outputs):
  - i_should_branch=1: q_pc_load=1, q_pc_value=i_result, q_done=1; no register write.
  - Else if i_op==`PRCO_OP_CMP: q_reg_we=1, q_reg_sel=`REG_SR (i_dst_reg ignored), q_reg_wdata=i_result, q_done=1.
  - Else: q_reg_we=1, q_reg_sel=i_dst_reg, q_reg_wdata=i_result, q_done=1.
  - i_op==`PRCO_OP_NOP with i_ce_reg: q_done only.
- RAM_WAIT:
  - q_ram_req, q_ram_we, q_ram_addr and q_ram_wdata are held stable.
  - On an edge sampling i_ram_ack=1: q_ram_req=0 and q_ram_we=0.
    - SW: q_done=1, q_busy=0, go to IDLE.
    - LW: capture i_ram_rdata into q_reg_wdata, go to WRITEBACK.
  - An ack in the same cycle req first rises is impossible (req is registered); an ack while not in RAM_WAIT is ignored.
- WRITEBACK: q_reg_we=1, q_reg_sel=latched dst, q_done=1, q_busy=0, go to IDLE.
- Strobes arriving while q_busy=1 are ignored (upstream contract); no state change.
- Pulse outputs (q_reg_we, q_pc_load, q_done) are high for exactly one cycle and return to 0 unless re-triggered.
- Back-to-back reg-path strobes retire on consecutive cycles.
- Address and data are passed unmodified (no wrap, no sign handling); the ALU owns arithmetic.
- Latency:
  - Reg path: 1 cycle.
  - SW: q_done one cycle after ack is sampled.
  - LW: q_reg_we/q_done two edges after ack is sampled.

Optional Feature:
- Macro: PRCO_MEM_WB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on RAM_WAIT entry and increments each RAM_WAIT cycle without ack.
  - On reaching TIMEOUT_CYCLES: q_ram_req=0, q_fault=1 (sticky until i_reset), q_done=1, no register write, go to IDLE.
  - An ack in the same cycle the limit is reached wins and is completed normally.
- Undefined: no counter; RAM_WAIT waits indefinitely; q_fault tied to 0.

Test Plan:
- Reset held 3 cycles mid-operation -> all outputs 0; IDLE next cycle.
- i_ce_reg, ADD op, i_result=16'h1234, dst=3 -> next cycle q_reg_we=1, sel=3, wdata=1234, q_done=1; both 0 the cycle after.
- i_ce_reg, CMP, i_result=16'h0005 -> q_reg_sel=`REG_SR, wdata=0005. Then JMP with i_should_branch=1, i_result=16'h0040 -> q_pc_load=1, q_pc_value=0040, q_reg_we=0.
- SW addr=16'h0010, data=16'hBEEF, ack after 4 cycles -> req/we/addr/wdata stable for 4 cycles, q_busy=1; q_done the cycle after ack; strobe during busy ignored.
- LW addr=16'h0020, ack with rdata=16'hCAFE, dst=2 -> q_reg_we=1, sel=2, wdata=CAFE two edges after ack; i_ce_ram and i_ce_reg together -> RAM path taken.
- With PRCO_MEM_WB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> req drops after 8 wait cycles, q_fault=1 sticky, q_done=1, no reg write; cleared only by i_reset.

Source files
------------

// File: rtl/prco_mem_wb.sv
// prco_mem_wb: memory-access / write-back stage behind the ALU.
//   Runs LW/SW on the data-RAM port, writes results to the register file,
//   issues PC redirects, and holds q_busy while a RAM access is in flight.
// Ports:
//   i_clk, i_reset (sync, active-high)
//   i_ce_ram / i_ce_reg   : one-cycle strobes from the ALU (RAM path wins)
//   i_op, i_result, i_store_data, i_dst_reg, i_should_branch : ALU payload
//   i_ram_ack, i_ram_rdata                : RAM response
//   q_ram_req/we/addr/wdata               : RAM request, held until ack
//   q_reg_we/sel/wdata                    : register-file write (pulse)
//   q_pc_load/q_pc_value                  : PC redirect (pulse)
//   q_busy, q_done (pulse), q_fault (sticky RAM timeout)
// Optional feature: define PRCO_MEM_WB_TIMEOUT_EN to abort a RAM access
// after TIMEOUT_CYCLES wait cycles; otherwise RAM_WAIT waits forever and
// q_fault is tied low.

`ifndef PRCO_OP_NOP
`define PRCO_OP_NOP 5'h00
`endif
`ifndef PRCO_OP_ADD
`define PRCO_OP_ADD 5'h01
`endif
`ifndef PRCO_OP_CMP
`define PRCO_OP_CMP 5'h07
`endif
`ifndef PRCO_OP_JMP
`define PRCO_OP_JMP 5'h0C
`endif
`ifndef PRCO_OP_LW
`define PRCO_OP_LW 5'h10
`endif
`ifndef PRCO_OP_SW
`define PRCO_OP_SW 5'h11
`endif
`ifndef REG_SR
`define REG_SR 3'd7
`endif

module prco_mem_wb #(
  parameter int DATA_W         = 16,
  parameter int REG_SEL_W      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce_ram,
  input  logic                 i_ce_reg,
  input  logic [4:0]           i_op,
  input  logic [DATA_W-1:0]    i_result,
  input  logic [DATA_W-1:0]    i_store_data,
  input  logic [REG_SEL_W-1:0] i_dst_reg,
  input  logic                 i_should_branch,
  input  logic                 i_ram_ack,
  input  logic [DATA_W-1:0]    i_ram_rdata,
  output logic                 q_ram_req,
  output logic                 q_ram_we,
  output logic [DATA_W-1:0]    q_ram_addr,
  output logic [DATA_W-1:0]    q_ram_wdata,
  output logic                 q_reg_we,
  output logic [REG_SEL_W-1:0] q_reg_sel,
  output logic [DATA_W-1:0]    q_reg_wdata,
  output logic                 q_pc_load,
  output logic [DATA_W-1:0]    q_pc_value,
  output logic                 q_busy,
  output logic                 q_done,
  output logic                 q_fault
);

  typedef enum logic [1:0] {IDLE, RAM_WAIT, WRITEBACK} state_e;

  state_e                state_q, state_d;
  logic                  ram_req_q, ram_req_d, ram_we_q, ram_we_d;
  logic [DATA_W-1:0]     ram_addr_q, ram_addr_d, ram_wdata_q, ram_wdata_d;
  logic                  reg_we_q, reg_we_d;
  logic [REG_SEL_W-1:0]  reg_sel_q, reg_sel_d, dst_q, dst_d;
  logic [DATA_W-1:0]     reg_wdata_q, reg_wdata_d, pc_value_q, pc_value_d;
  logic                  pc_load_q, pc_load_d, busy_q, busy_d, done_q, done_d;
  // While waiting, ram_we_q doubles as the latched "this is a SW" flag.
  logic                  is_sw;
  assign is_sw = ram_we_q;

`ifdef PRCO_MEM_WB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       fault_q, fault_d;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    reg_sel_d   = reg_sel_q;
    reg_wdata_d = reg_wdata_q;
    pc_value_d  = pc_value_q;
    dst_d       = dst_q;
    busy_d      = busy_q;
    reg_we_d    = 1'b0;
    pc_load_d   = 1'b0;
    done_d      = 1'b0;
`ifdef PRCO_MEM_WB_TIMEOUT_EN
    cnt_d       = cnt_q;
    fault_d     = fault_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_ce_ram) begin
          ram_req_d   = 1'b1;
          ram_we_d    = (i_op == `PRCO_OP_SW);
          ram_addr_d  = i_result;
          ram_wdata_d = i_store_data;
          dst_d       = i_dst_reg;
          busy_d      = 1'b1;
          state_d     = RAM_WAIT;
`ifdef PRCO_MEM_WB_TIMEOUT_EN
          cnt_d       = 8'd0;
`endif
        end else if (i_ce_reg) begin
          done_d = 1'b1;
          if (i_should_branch) begin
            pc_load_d  = 1'b1;
            pc_value_d = i_result;
          end else if (i_op != `PRCO_OP_NOP) begin
            reg_we_d    = 1'b1;
            reg_sel_d   = (i_op == `PRCO_OP_CMP) ? `REG_SR : i_dst_reg;
            reg_wdata_d = i_result;
          end
        end
      end
      RAM_WAIT: begin
        if (i_ram_ack) begin
          ram_req_d = 1'b0;
          ram_we_d  = 1'b0;
          if (is_sw) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            reg_wdata_d = i_ram_rdata;
            state_d     = WRITEBACK;
          end
        end
`ifdef PRCO_MEM_WB_TIMEOUT_EN
        // Ack is checked first so a same-cycle ack beats the timeout.
        else if (cnt_q == TMO_LAST) begin
          ram_req_d = 1'b0;
          ram_we_d  = 1'b0;
          fault_d   = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      WRITEBACK: begin
        reg_we_d  = 1'b1;
        reg_sel_d = dst_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_sel_q   <= '0;
      reg_wdata_q <= '0;
      pc_load_q   <= 1'b0;
      pc_value_q  <= '0;
      dst_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef PRCO_MEM_WB_TIMEOUT_EN
      cnt_q       <= 8'd0;
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_sel_q   <= reg_sel_d;
      reg_wdata_q <= reg_wdata_d;
      pc_load_q   <= pc_load_d;
      pc_value_q  <= pc_value_d;
      dst_q       <= dst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef PRCO_MEM_WB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      fault_q     <= fault_d;
`endif
    end
  end

  assign q_ram_req   = ram_req_q;
  assign q_ram_we    = ram_we_q;
  assign q_ram_addr  = ram_addr_q;
  assign q_ram_wdata = ram_wdata_q;
  assign q_reg_we    = reg_we_q;
  assign q_reg_sel   = reg_sel_q;
  assign q_reg_wdata = reg_wdata_q;
  assign q_pc_load   = pc_load_q;
  assign q_pc_value  = pc_value_q;
  assign q_busy      = busy_q;
  assign q_done      = done_q;
`ifdef PRCO_MEM_WB_TIMEOUT_EN
  assign q_fault     = fault_q;
`else
  assign q_fault     = 1'b0;
`endif

endmodule

// File: tb/tb_prco_mem_wb.sv
// Directed + randomized bench for prco_mem_wb. Expected values come from the
// instruction-level rules: what each retired instruction must produce and
// how many cycles the RAM request must stay up.

`ifndef PRCO_OP_NOP
`define PRCO_OP_NOP 5'h00
`endif
`ifndef PRCO_OP_ADD
`define PRCO_OP_ADD 5'h01
`endif
`ifndef PRCO_OP_CMP
`define PRCO_OP_CMP 5'h07
`endif
`ifndef PRCO_OP_JMP
`define PRCO_OP_JMP 5'h0C
`endif
`ifndef PRCO_OP_LW
`define PRCO_OP_LW 5'h10
`endif
`ifndef PRCO_OP_SW
`define PRCO_OP_SW 5'h11
`endif
`ifndef REG_SR
`define REG_SR 3'd7
`endif

module tb_prco_mem_wb;
  logic        i_clk = 1'b0;
  logic        i_reset, i_ce_ram, i_ce_reg, i_should_branch, i_ram_ack;
  logic [4:0]  i_op;
  logic [15:0] i_result, i_store_data, i_ram_rdata;
  logic [2:0]  i_dst_reg;
  logic        q_ram_req, q_ram_we, q_reg_we, q_pc_load, q_busy, q_done, q_fault;
  logic [15:0] q_ram_addr, q_ram_wdata, q_reg_wdata, q_pc_value;
  logic [2:0]  q_reg_sel;

  int total = 0;
  int bad   = 0;

  prco_mem_wb #(.DATA_W(16), .REG_SEL_W(3), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_ce_ram(i_ce_ram), .i_ce_reg(i_ce_reg),
    .i_op(i_op), .i_result(i_result), .i_store_data(i_store_data),
    .i_dst_reg(i_dst_reg), .i_should_branch(i_should_branch),
    .i_ram_ack(i_ram_ack), .i_ram_rdata(i_ram_rdata),
    .q_ram_req(q_ram_req), .q_ram_we(q_ram_we), .q_ram_addr(q_ram_addr),
    .q_ram_wdata(q_ram_wdata), .q_reg_we(q_reg_we), .q_reg_sel(q_reg_sel),
    .q_reg_wdata(q_reg_wdata), .q_pc_load(q_pc_load), .q_pc_value(q_pc_value),
    .q_busy(q_busy), .q_done(q_done), .q_fault(q_fault)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    i_ce_ram = 0; i_ce_reg = 0; i_should_branch = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req"},   32'(q_ram_req),   0);
    chk({tag, ".we"},    32'(q_ram_we),    0);
    chk({tag, ".addr"},  32'(q_ram_addr),  0);
    chk({tag, ".rwd"},   32'(q_ram_wdata), 0);
    chk({tag, ".regwe"}, 32'(q_reg_we),    0);
    chk({tag, ".sel"},   32'(q_reg_sel),   0);
    chk({tag, ".wd"},    32'(q_reg_wdata), 0);
    chk({tag, ".pcld"},  32'(q_pc_load),   0);
    chk({tag, ".pcv"},   32'(q_pc_value),  0);
    chk({tag, ".busy"},  32'(q_busy),      0);
    chk({tag, ".done"},  32'(q_done),      0);
    chk({tag, ".fault"}, 32'(q_fault),     0);
  endtask

  // Register-path instruction: issue, then compare with its retirement rule.
  task automatic reg_instr(input logic [4:0] op, input logic br,
                           input logic [15:0] res, input logic [2:0] dst);
    logic       exp_we;
    logic [2:0] exp_sel;
    i_ce_reg = 1; i_ce_ram = 0; i_op = op; i_should_branch = br;
    i_result = res; i_dst_reg = dst;
    tick();
    clr();
    exp_we  = !br && (op != `PRCO_OP_NOP);
    exp_sel = (op == `PRCO_OP_CMP) ? `REG_SR : dst;
    chk("reg.done", 32'(q_done),    1);
    chk("reg.pcld", 32'(q_pc_load), 32'(br));
    chk("reg.we",   32'(q_reg_we),  32'(exp_we));
    chk("reg.busy", 32'(q_busy),    0);
    if (br)     chk("reg.pcv", 32'(q_pc_value), 32'(res));
    if (exp_we) begin
      chk("reg.sel", 32'(q_reg_sel),   32'(exp_sel));
      chk("reg.wd",  32'(q_reg_wdata), 32'(res));
    end
  endtask

  // RAM instruction with ack on the d-th wait cycle; optionally a stray
  // register strobe is driven during the wait and must be ignored.
  task automatic ram_instr(input logic sw, input logic also_reg, input logic [15:0] addr,
                           input logic [15:0] sdata, input logic [2:0] dst,
                           input logic [15:0] rdata, input int d, input logic noise);
    i_ce_ram = 1; i_ce_reg = also_reg; i_op = sw ? `PRCO_OP_SW : `PRCO_OP_LW;
    i_result = addr; i_store_data = sdata; i_dst_reg = dst;
    tick();
    clr();
    i_result = 16'h5A5A; i_store_data = 16'hA5A5;
    for (int k = 0; k < d; k++) begin
      chk("ram.req",   32'(q_ram_req),   1);
      chk("ram.we",    32'(q_ram_we),    32'(sw));
      chk("ram.addr",  32'(q_ram_addr),  32'(addr));
      chk("ram.wdata", 32'(q_ram_wdata), 32'(sdata));
      chk("ram.busy",  32'(q_busy),      1);
      chk("ram.regwe", 32'(q_reg_we),    0);
      chk("ram.done",  32'(q_done),      0);
      i_ce_reg = noise && (k % 2 == 0);
      i_op = `PRCO_OP_ADD;
      if (k == d - 1) begin
        i_ram_ack = 1; i_ram_rdata = rdata; i_ce_reg = 0;
      end
      tick();
    end
    i_ram_ack = 0; i_ram_rdata = 16'hDEAD; i_ce_reg = 0;
    chk("ack.req", 32'(q_ram_req), 0);
    chk("ack.we",  32'(q_ram_we),  0);
    if (sw) begin
      chk("sw.done",  32'(q_done),   1);
      chk("sw.busy",  32'(q_busy),   0);
      chk("sw.regwe", 32'(q_reg_we), 0);
    end else begin
      chk("lw.mid.done", 32'(q_done),   0);
      chk("lw.mid.we",   32'(q_reg_we), 0);
      tick();
      chk("lw.we",   32'(q_reg_we),    1);
      chk("lw.sel",  32'(q_reg_sel),   32'(dst));
      chk("lw.wd",   32'(q_reg_wdata), 32'(rdata));
      chk("lw.done", 32'(q_done),      1);
      chk("lw.busy", 32'(q_busy),      0);
    end
    tick();
    chk("post.done", 32'(q_done),   0);
    chk("post.we",   32'(q_reg_we), 0);
  endtask

  initial begin
    i_reset = 1; clr(); i_ram_ack = 0; i_op = 0; i_result = 0;
    i_store_data = 0; i_dst_reg = 0; i_ram_rdata = 0;
    tick(); tick();
    i_reset = 0;
    chk_all_zero("rst0");

    // Reset held 3 cycles in the middle of an SW.
    i_ce_ram = 1; i_op = `PRCO_OP_SW; i_result = 16'h0033; i_store_data = 16'h7777;
    tick(); clr();
    chk("mid.req", 32'(q_ram_req), 1);
    i_reset = 1;
    tick(); tick(); tick();
    chk_all_zero("rst3");
    i_reset = 0;
    i_ram_ack = 1;   // stray ack in IDLE must be ignored
    tick();
    i_ram_ack = 0;
    chk("idle.req",  32'(q_ram_req), 0);
    chk("idle.busy", 32'(q_busy),    0);
    chk("idle.done", 32'(q_done),    0);

    // Directed register-path cases.
    reg_instr(`PRCO_OP_ADD, 0, 16'h1234, 3'd3);
    tick();
    chk("add.we.off",   32'(q_reg_we), 0);
    chk("add.done.off", 32'(q_done),   0);
    reg_instr(`PRCO_OP_CMP, 0, 16'h0005, 3'd1);
    reg_instr(`PRCO_OP_JMP, 1, 16'h0040, 3'd4);
    reg_instr(`PRCO_OP_NOP, 0, 16'h9999, 3'd5);
    tick();
    chk("nop.done.off", 32'(q_done), 0);

    // Directed RAM cases: SW with ack after 4 cycles and a busy strobe,
    // LW with both strobes high.
    ram_instr(1, 0, 16'h0010, 16'hBEEF, 3'd0, 16'h0000, 4, 1);
    ram_instr(0, 1, 16'h0020, 16'h1111, 3'd2, 16'hCAFE, 3, 0);

    // Randomized mix; reg-path instructions run back-to-back.
    for (int n = 0; n < 60; n++) begin
      int kind = $urandom_range(0, 5);
      if (kind <= 3) begin
        logic [4:0] ops[5] = '{`PRCO_OP_NOP, `PRCO_OP_ADD, `PRCO_OP_CMP, `PRCO_OP_JMP, 5'h02};
        reg_instr(ops[$urandom_range(0, 4)], 1'($urandom_range(0, 3) == 0),
                  16'($urandom), 3'($urandom));
      end else begin
        ram_instr(1'(kind == 4), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                  3'($urandom), 16'($urandom), $urandom_range(1, 6), 1'($urandom_range(0, 1)));
      end
      chk("rnd.fault", 32'(q_fault), 0);
    end

`ifdef PRCO_MEM_WB_TIMEOUT_EN
    begin
      int n;
      i_ce_ram = 1; i_op = `PRCO_OP_LW; i_result = 16'h0080; i_dst_reg = 3'd6;
      tick(); clr();
      n = 0;
      while (q_ram_req === 1'b1 && n < 50) begin
        chk("tmo.regwe", 32'(q_reg_we), 0);
        tick();
        n++;
      end
      chk("tmo.cycles", 32'(n), 8);
      chk("tmo.fault",  32'(q_fault),  1);
      chk("tmo.done",   32'(q_done),   1);
      chk("tmo.regwe2", 32'(q_reg_we), 0);
      chk("tmo.busy",   32'(q_busy),   0);
      tick();
      chk("tmo.sticky", 32'(q_fault), 1);
      chk("tmo.done0",  32'(q_done),  0);
      reg_instr(`PRCO_OP_ADD, 0, 16'h0101, 3'd1);
      chk("tmo.sticky2", 32'(q_fault), 1);
      i_reset = 1; tick(); i_reset = 0;
      chk("tmo.clear", 32'(q_fault), 0);
    end
`else
    // Without the timeout a long wait must simply keep waiting.
    ram_instr(0, 0, 16'h0080, 16'h0000, 3'd6, 16'h1357, 40, 0);
    chk("nofault", 32'(q_fault), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
